// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; accept->rsp_valid in 1 edge (MUL_CYCLES for multiply).
// Requests are refused while an op is in flight; the response is held stable until rsp_ready.
module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_srcA,
  input  logic [WIDTH-1:0] req0_srcB,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_srcA,
  input  logic [WIDTH-1:0] req1_srcB,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_id
);

  localparam int         CNT_W  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               grant0;
  logic               grant1;
  logic               accept;
  logic [WIDTH-1:0]   acc_srcA;
  logic [WIDTH-1:0]   acc_srcB;
  logic [2:0]         acc_op;

  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        // rr_ptr only breaks ties; a lone requester always wins
        grant0 = req0_valid && (!req1_valid || !rr_ptr);
        grant1 = req1_valid && (!req0_valid ||  rr_ptr);
        if (grant0 || grant1) state_nxt = EXEC;
      end
      EXEC:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;
  assign acc_srcA   = grant1 ? req1_srcA : req0_srcA;
  assign acc_srcB   = grant1 ? req1_srcB : req0_srcB;
  assign acc_op     = grant1 ? req1_op   : req0_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= 1'b0;
      cnt         <= '0;
      alu_srcA    <= '0;
      alu_srcB    <= '0;
      alu_control <= 3'b000;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_id      <= 1'b0;
    end else begin
      if (accept) begin
        alu_srcA    <= acc_srcA;
        alu_srcB    <= acc_srcB;
        alu_control <= acc_op;
        rsp_id      <= grant1;
        rr_ptr      <= ~grant1;
        cnt         <= (acc_op == OP_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
      end
      if (state == EXEC) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= 1'b1;
        end
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule
